// File: rtl/exu_wb_arbiter.sv
// Integer register-file writeback arbiter: per-source FIFOs drained
// round-robin into one registered write port toward IDU1.
module exu_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int NSRC  = 4,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC-1:0]      src_valid,
    input  logic [NSRC*5-1:0]    src_rd_addr,
    input  logic [NSRC*XLEN-1:0] src_data,
    input  logic [NSRC*XLEN-1:0] src_instr_tag,
    input  logic [NSRC*32-1:0]   src_instr,
    output logic [NSRC-1:0]      src_stall,
    output logic [XLEN-1:0]      wb_data,
    output logic [4:0]           wb_rd_addr,
    output logic                 wb_rd_wr_en,
    output logic [XLEN-1:0]      wb_instr_tag,
    output logic [31:0]          wb_instr,
    output logic                 busy,
    output logic                 overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] tag;
        logic [31:0]     instr;
    } entry_t;

    entry_t        mem    [NSRC][DEPTH];
    logic [AW-1:0] wr_ptr [NSRC];
    logic [AW-1:0] rd_ptr [NSRC];
    logic [CW-1:0] count  [NSRC];
    logic [IW-1:0] rr_ptr;

    logic [NSRC-1:0] req;
    logic [NSRC-1:0] full;
    logic [NSRC-1:0] nonempty;
    logic [NSRC-1:0] push;
    logic [NSRC-1:0] pop;
    logic            push_err;
    logic            grant;
    logic [IW-1:0]   win;
    logic [IW-1:0]   cand;
    entry_t          head;

    // Writes to x0 are swallowed here so they never occupy a slot.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            req[i]      = src_valid[i] && (src_rd_addr[5*i +: 5] != 5'd0);
            full[i]     = (count[i] == FULL);
            nonempty[i] = (count[i] != '0);
        end
    end

    assign src_stall = full;
    assign push      = req & ~full;
    assign push_err  = |(req & full);
    assign busy      = (|nonempty) || wb_rd_wr_en;

    always_comb begin
        grant = 1'b0;
        win   = rr_ptr;
        cand  = rr_ptr;
        for (int k = 1; k <= NSRC; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NSRC);
            if (!grant && nonempty[cand]) begin
                grant = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            pop[i] = grant && (win == IW'(i));
        end
    end

    assign head = mem[win][rd_ptr[win]];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= {src_rd_addr[5*i +: 5],
                                      src_data[XLEN*i +: XLEN],
                                      src_instr_tag[XLEN*i +: XLEN],
                                      src_instr[32*i +: 32]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr       <= IW'(NSRC - 1);
            wb_rd_wr_en  <= 1'b0;
            wb_rd_addr   <= '0;
            wb_data      <= '0;
            wb_instr_tag <= '0;
            wb_instr     <= '0;
            overflow     <= 1'b0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + 1'b1;
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
            if (push_err) overflow <= 1'b1;
            if (grant)    rr_ptr   <= win;
            // Idle cycles drive zeros so downstream OR-merges stay clean.
            wb_rd_wr_en <= grant;
            if (grant) begin
                wb_rd_addr   <= head.rd;
                wb_data      <= head.data;
                wb_instr_tag <= head.tag;
                wb_instr     <= head.instr;
            end else begin
                wb_rd_addr   <= '0;
                wb_data      <= '0;
                wb_instr_tag <= '0;
                wb_instr     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Scoreboard bench for exu_wb_arbiter: directed pushes queue expected
// writebacks, an independent negedge monitor retires and compares them.
module tb_exu_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int NSRC  = 4;
    localparam int DEPTH = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NSRC-1:0]      src_valid;
    logic [NSRC*5-1:0]    src_rd_addr;
    logic [NSRC*XLEN-1:0] src_data;
    logic [NSRC*XLEN-1:0] src_instr_tag;
    logic [NSRC*32-1:0]   src_instr;
    logic [NSRC-1:0]      src_stall;
    logic [XLEN-1:0]      wb_data;
    logic [4:0]           wb_rd_addr;
    logic                 wb_rd_wr_en;
    logic [XLEN-1:0]      wb_instr_tag;
    logic [31:0]          wb_instr;
    logic                 busy;
    logic                 overflow;

    exu_wb_arbiter #(.XLEN(XLEN), .NSRC(NSRC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src_valid     (src_valid),
        .src_rd_addr   (src_rd_addr),
        .src_data      (src_data),
        .src_instr_tag (src_instr_tag),
        .src_instr     (src_instr),
        .src_stall     (src_stall),
        .wb_data       (wb_data),
        .wb_rd_addr    (wb_rd_addr),
        .wb_rd_wr_en   (wb_rd_wr_en),
        .wb_instr_tag  (wb_instr_tag),
        .wb_instr      (wb_instr),
        .busy          (busy),
        .overflow      (overflow)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] tag;
        logic [31:0] instr;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] instr_of(logic [4:0] rd);
        return 32'h0000_0013 | (32'(rd) << 7);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic idle();
        src_valid     = '0;
        src_rd_addr   = '0;
        src_data      = '0;
        src_instr_tag = '0;
        src_instr     = '0;
    endtask

    task automatic drive(int i, logic [4:0] rd, logic [31:0] d);
        src_valid[i]           = 1'b1;
        src_rd_addr[5*i +: 5]  = rd;
        src_data[32*i +: 32]   = d;
        src_instr_tag[32*i +: 32] = ~d;
        src_instr[32*i +: 32]  = instr_of(rd);
    endtask

    task automatic expect_wb(logic [4:0] rd, logic [31:0] d, int at);
        exp_t e;
        e.rd    = rd;
        e.data  = d;
        e.tag   = ~d;
        e.instr = instr_of(rd);
        e.cyc   = at;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_rd_wr_en) begin
                if (sbq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no writeback (cycle %0d)",
                             wb_rd_addr, wb_data, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("wb_cycle", 64'(cyc), 64'(e.cyc));
                    chk("wb_rd", 64'(wb_rd_addr), 64'(e.rd));
                    chk("wb_data", 64'(wb_data), 64'(e.data));
                    chk("wb_tag", 64'(wb_instr_tag), 64'(e.tag));
                    chk("wb_instr", 64'(wb_instr), 64'(e.instr));
                end
            end else begin
                chk("wb_idle_zero",
                    64'(wb_data | wb_instr_tag | wb_instr | 32'(wb_rd_addr)), 64'd0);
            end
        end
    end

    initial begin
        int c;
        int j;
        int guard;
        int s;
        int n[2];
        int run[2];
        int maxrun;

        idle();
        do_reset();
        mon_en = 1'b1;
        chk("rst_wr_en", 64'(wb_rd_wr_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_stall", 64'(src_stall), 64'd0);

        // single alu write, 2-cycle latency
        tick();
        c = cyc;
        drive(0, 5'd5, 32'hDEAD_BEEF);
        expect_wb(5'd5, 32'hDEAD_BEEF, c + 2);
        tick();
        idle();
        tick();
        tick();
        chk("single_off_en", 64'(wb_rd_wr_en), 64'd0);
        chk("single_off_data", 64'(wb_data), 64'd0);
        tick();

        // reset with three queued entries; src0 must regain priority
        tick();
        c = cyc;
        drive(0, 5'd7, 32'h77);
        drive(1, 5'd8, 32'h88);
        drive(2, 5'd9, 32'h99);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_wr_en", 64'(wb_rd_wr_en), 64'd0);
            chk("mid_rst_stall", 64'(src_stall), 64'd0);
            chk("mid_rst_overflow", 64'(overflow), 64'd0);
            chk("mid_rst_busy", 64'(busy), 64'd0);
            tick();
        end
        c = cyc;
        drive(0, 5'd10, 32'hA0);
        drive(1, 5'd11, 32'hB1);
        expect_wb(5'd10, 32'hA0, c + 2);
        expect_wb(5'd11, 32'hB1, c + 3);
        tick();
        idle();
        repeat (4) tick();

        // four-way collision
        do_reset();
        tick();
        c = cyc;
        for (int i = 0; i < NSRC; i++) begin
            drive(i, 5'(i + 1), 32'h11 * (i + 1));
            expect_wb(5'(i + 1), 32'h11 * (i + 1), c + 2 + i);
        end
        tick();
        idle();
        repeat (4) tick();
        chk("coll_busy_c5", 64'(busy), 64'd1);
        tick();
        chk("coll_busy_c6", 64'(busy), 64'd0);

        // round-robin fairness between src0 and src3
        do_reset();
        tick();
        c = cyc;
        j = 0;
        guard = 0;
        maxrun = 0;
        n[0] = 0; n[1] = 0;
        run[0] = 0; run[1] = 0;
        while ((n[0] < 6 || n[1] < 6) && guard < 40) begin
            idle();
            for (int k = 0; k < 2; k++) begin
                s = k * 3;
                if (n[k] < 6) begin
                    if (!src_stall[s]) begin
                        drive(s, 5'(12 + k), 32'(32'h100 * (s + 1) + n[k]));
                        expect_wb(5'(12 + k), 32'(32'h100 * (s + 1) + n[k]), c + 2 + j);
                        j++;
                        n[k]++;
                        run[k] = 0;
                    end else begin
                        run[k]++;
                        if (run[k] > maxrun) maxrun = run[k];
                    end
                end
            end
            tick();
            guard++;
        end
        idle();
        chk("rr_push_budget", 64'(guard < 40), 64'd1);
        chk("rr_max_stall_ok", 64'(maxrun <= 2), 64'd1);
        repeat (14) tick();

        // fill src3 behind higher-priority traffic, then force a push
        do_reset();
        tick();
        c = cyc;
        for (int i = 0; i < NSRC; i++) begin
            drive(i, 5'(i + 1), 32'h41 + i);
            expect_wb(5'(i + 1), 32'h41 + i, c + 2 + i);
        end
        tick();
        idle();
        chk("full_stall_c1", 64'(src_stall[3]), 64'd0);
        drive(3, 5'd5, 32'h45);
        expect_wb(5'd5, 32'h45, c + 6);
        tick();
        idle();
        chk("full_stall_c2", 64'(src_stall[3]), 64'd1);
        chk("full_ovf_before", 64'(overflow), 64'd0);
        drive(3, 5'd6, 32'hBAD);
        tick();
        idle();
        chk("full_ovf_set", 64'(overflow), 64'd1);
        chk("full_stall_c3", 64'(src_stall[3]), 64'd1);
        repeat (5) tick();
        chk("full_ovf_sticky", 64'(overflow), 64'd1);
        chk("full_stall_drained", 64'(src_stall), 64'd0);

        // x0 writes are dropped
        do_reset();
        tick();
        drive(3, 5'd0, 32'hFFFF_FFFF);
        tick();
        idle();
        chk("x0_busy_c1", 64'(busy), 64'd0);
        chk("x0_stall_c1", 64'(src_stall), 64'd0);
        tick();
        chk("x0_busy_c2", 64'(busy), 64'd0);
        chk("x0_overflow", 64'(overflow), 64'd0);

        repeat (3) tick();
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/exu_wb_arbiter.md
Name: exu_wb_arbiter

Overview:
- Shares the single integer register-file write port among the EXU functional units: alu, mul, div and lsu.
- Each unit's writeback goes into a small per-source FIFO. A round-robin arbiter drains one entry per cycle into a registered writeback port toward IDU1.
- Replaces the one-hot OR-merge of unit writebacks, so units may complete in the same cycle without corrupting data.
- Gives each source a stall (backpressure) signal.

Parameters:
- XLEN, 32, data width and debug-tag width.
- NSRC, 4, number of writeback sources. Index 0=alu, 1=mul, 2=div, 3=lsu.
- DEPTH, 2, entries per source FIFO. Must be a power of two, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- src_valid  in  NSRC  per-source writeback request, one cycle per result
- src_rd_addr  in  NSRC*5  destination register. Slice i is [5i+4:5i].
- src_data  in  NSRC*XLEN  writeback data
- src_instr_tag  in  NSRC*XLEN  debug instruction tag
- src_instr  in  NSRC*32  debug instruction word
- src_stall  out  NSRC  FIFO i is full; source i must hold off
- wb_data  out  XLEN  registered writeback data
- wb_rd_addr  out  5  registered destination register
- wb_rd_wr_en  out  1  registered write strobe
- wb_instr_tag  out  XLEN  debug tag of the retiring entry
- wb_instr  out  32  debug instruction of the retiring entry
- busy  out  1  any FIFO non-empty, or wb_rd_wr_en high
- overflow  out  1  sticky error: a push was attempted while src_stall was high

Behaviour:
- Reset (rst_n low at a clock edge):
  - All FIFO counts, read pointers and write pointers go to 0.
  - rr_ptr goes to NSRC-1, so source 0 has first priority.
  - wb_data, wb_rd_addr, wb_rd_wr_en, wb_instr_tag, wb_instr, overflow and busy all go to 0.
  - Reset mid-operation discards every queued entry. No writeback is issued in the cycle after reset.
- Enqueue (per source i):
  - If src_valid[i] is high, src_stall[i] is low and rd_addr is non-zero, the entry {rd, data, tag, instr} is written at wr_ptr[i] on the clock edge. wr_ptr increments modulo DEPTH.
  - If rd_addr is 0 the request is consumed but not queued: no write and no stall effect.
- src_stall[i] = (count[i] == DEPTH). It is combinational from the registered count.
- A push while full is dropped and sets overflow. This holds even if the same FIFO is dequeued in that cycle.
- Arbitration (combinational, each cycle):
  - Candidates are the FIFOs with count non-zero.
  - Search starts at rr_ptr+1 and wraps modulo NSRC. The first non-empty source wins and is popped at the clock edge.
  - rr_ptr is updated to the winner index only when a grant occurs.
  - Exactly one grant per cycle at most.
- Output register, at each edge:
  - With a grant: wb_rd_wr_en=1, and the other wb_* fields take the head entry of the winning FIFO.
  - Without a grant: wb_rd_wr_en=0 and wb_data/wb_rd_addr/tag/instr go to 0. This keeps the OR-merge-compatible zero idle value.
- Latency: src_valid high in cycle 0 with all FIFOs empty gives wb_rd_wr_en high in cycle 2. There is no bypass path.
- Simultaneous push and pop on the same FIFO: count is unchanged, and both pointers advance.
  - When count is 0, a same-cycle push is not poppable until the next cycle.
- Ordering:
  - Entries from the same source retire in enqueue order.
  - Ordering across sources is not guaranteed. The IDU1 scoreboard resolves register hazards.
- Throughput: 1 writeback/cycle sustained. Under continuous load, no source waits more than NSRC-1 grants between its own grants.
- Pointer wrap-around: each pointer is log2(DEPTH) bits wide, and count is log2(DEPTH)+1 bits wide.
- overflow clears only on reset.

Test Plan:
- Single write: alu pushes rd=5, data=0xDEADBEEF in cycle 0 → cycle 2 shows wb_rd_wr_en=1, wb_rd_addr=5, wb_data=0xDEADBEEF. Cycle 3 shows wb_rd_wr_en=0 and wb_data=0.
- Four-way collision: all sources push in cycle 0 with rd=1..4 and data=0x11,0x22,0x33,0x44 → writebacks on cycles 2,3,4,5 in order src0,1,2,3. busy falls in cycle 6.
- Round-robin fairness: src0 and src3 push continuously while respecting src_stall → grants alternate 0,3,0,3. Neither source stalls for more than 2 consecutive cycles once steady state is reached.
- Full/stall: a source pushes with no grants available to it (other sources hold priority) → src_stall rises after DEPTH=2 entries. A forced push while stalled sets overflow=1 and the data never appears on wb.
- x0 filter: lsu pushes rd=0, data=0xFFFFFFFF → no writeback occurs, the count stays 0 and busy stays 0.
- Reset mid-operation: queue 3 entries, assert rst_n=0 for 1 cycle → all wb_* are 0 for the next 3 cycles, src_stall=0, overflow=0. The next push returns in 2 cycles with src0 priority.
